engine_read_write_request_gen: RTL and testbench

Downstream stage of the read/write engine kernel. It accepts the kernel's registered address/data packets, buffers them, and issues memory requests (read or write) over a valid/ready channel with a bounded number of outstanding transactions. In-order memory responses are merged with the buffered original packet and forwarded downstream. It sits between `engine_read_write_kernel` and the engine's memory/cache port.

---
 rtl/global_package.sv | 36 +++
 rtl/engine_read_write_request_gen_if.sv | 22 ++
 rtl/engine_read_write_request_gen_fifo.sv | 64 ++++++
 rtl/engine_read_write_request_gen.sv | 187 ++++++++++++++++++
 tb/tb_engine_read_write_request_gen.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/global_package.sv
// Shared types for the read/write engine: packet layouts, request command
// encoding and the request generator state set.
package global_package;

    localparam int unsigned ENGINE_FIELD_W    = 32;
    localparam int unsigned ENGINE_NUM_FIELDS = 2;
    localparam int unsigned MEM_ID_W          = 8;

    typedef struct packed {
        logic [ENGINE_NUM_FIELDS-1:0][ENGINE_FIELD_W-1:0] field;
    } EnginePacketData;

    typedef struct packed {
        logic [31:0] offset;
    } PacketDataAddress;

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } ReadWriteCmd;

    typedef struct packed {
        logic [63:0]               address;
        logic [ENGINE_FIELD_W-1:0] data;
        ReadWriteCmd               cmd;
        logic [MEM_ID_W-1:0]       id_buffer;
    } MemoryRequestPacket;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DRAIN,
        S_DONE
    } engine_read_write_request_gen_state;

endpackage

// File: rtl/engine_read_write_request_gen_if.sv
// Memory-side request/response channel of the read/write request generator.
interface engine_read_write_request_gen_if;
    import global_package::*;

    logic                      mem_req_valid_out;
    logic                      mem_req_ready_in;
    MemoryRequestPacket        mem_req_out;
    logic                      mem_resp_valid_in;
    logic                      mem_resp_ready_out;
    logic [ENGINE_FIELD_W-1:0] mem_resp_data_in;

    modport master (
        output mem_req_valid_out, mem_req_out, mem_resp_ready_out,
        input  mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in
    );

    modport slave (
        input  mem_req_valid_out, mem_req_out, mem_resp_ready_out,
        output mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in
    );

endinterface

// File: rtl/engine_read_write_request_gen_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and flush.
module fifo_sync_fwft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/engine_read_write_request_gen.sv
// Buffers kernel packets, issues bounded in-flight memory requests and merges
// in-order responses with the original packet for the downstream stage.
module engine_read_write_request_gen
    import global_package::*;
#(
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned PROG_FULL_MARGIN = 3,
    parameter int unsigned MAX_OUTSTANDING  = 8
) (
    input  logic                                   ap_clk,
    input  logic                                   areset_n,
    input  logic                                   clear_in,
    input  logic                                   start_in,
    input  logic                                   done_in,
    input  logic                                   cmd_write_in,
    input  logic [63:0]                            base_address_in,
    input  logic                                   valid_in,
    input  PacketDataAddress                       address_in,
    input  EnginePacketData                        data_in,
    output logic                                   prog_full_out,
    engine_read_write_request_gen_if.master        mem_if,
    output logic                                   result_valid_out,
    input  logic                                   result_ready_in,
    output EnginePacketData                        result_out,
    output logic                                   done_out,
    output logic                                   error_out
);

    localparam int unsigned IN_W = $bits(PacketDataAddress) + $bits(EnginePacketData);
    localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OW   = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] PROG_FULL_LEVEL = CW'(FIFO_DEPTH - PROG_FULL_MARGIN);

    engine_read_write_request_gen_state state_q, state_d;
    logic [63:0]         base_q, base_d;
    ReadWriteCmd         cmd_q, cmd_d;
    logic [MEM_ID_W-1:0] id_q, id_d;
    logic                req_valid_q, req_valid_d;
    MemoryRequestPacket  req_q, req_d;
    logic                res_valid_q, res_valid_d;
    EnginePacketData     res_q, res_d;
    logic                prog_full_q, prog_full_d;
    logic                error_q, error_d;

    logic             in_push, in_empty, in_full;
    logic [CW-1:0]    in_count;
    logic [IN_W-1:0]  in_dout;
    PacketDataAddress head_addr;
    EnginePacketData  head_data;
    logic             meta_empty, meta_full;
    EnginePacketData  meta_dout;
    logic [OW-1:0]    outstanding;
    logic             issue, resp_ready, resp_hs;

    assign in_push = valid_in && (state_q != S_DONE);
    assign {head_addr, head_data} = in_dout;

    fifo_sync_fwft #(.WIDTH(IN_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk   (ap_clk),
        .rst_n (areset_n),
        .clear (clear_in),
        .push  (in_push),
        .din   ({address_in, data_in}),
        .pop   (issue),
        .dout  (in_dout),
        .empty (in_empty),
        .full  (in_full),
        .count (in_count)
    );

    // The metadata FIFO holds exactly one entry per issued, unanswered request,
    // so its occupancy doubles as the outstanding counter.
    fifo_sync_fwft #(.WIDTH($bits(EnginePacketData)), .DEPTH(MAX_OUTSTANDING)) u_meta_fifo (
        .clk   (ap_clk),
        .rst_n (areset_n),
        .clear (clear_in),
        .push  (issue),
        .din   (head_data),
        .pop   (resp_hs),
        .dout  (meta_dout),
        .empty (meta_empty),
        .full  (meta_full),
        .count (outstanding)
    );

    assign issue = ((state_q == S_BUSY) || (state_q == S_DRAIN)) && !in_empty && !meta_full
                   && (!req_valid_q || mem_if.mem_req_ready_in);
    assign resp_ready = !meta_empty && (!res_valid_q || result_ready_in);
    assign resp_hs    = mem_if.mem_resp_valid_in && resp_ready;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        cmd_d       = cmd_q;
        id_d        = id_q;
        req_valid_d = req_valid_q;
        req_d       = req_q;
        res_valid_d = res_valid_q;
        res_d       = res_q;
        prog_full_d = (in_count >= PROG_FULL_LEVEL);
        error_d     = error_q;
        if (clear_in) begin
            state_d     = S_IDLE;
            base_d      = '0;
            cmd_d       = CMD_READ;
            id_d        = '0;
            req_valid_d = 1'b0;
            req_d       = '0;
            res_valid_d = 1'b0;
            res_d       = '0;
            prog_full_d = 1'b0;
            error_d     = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        state_d = S_BUSY;
                        base_d  = base_address_in;
                        cmd_d   = ReadWriteCmd'(cmd_write_in);
                    end
                end
                S_BUSY:  if (done_in) state_d = S_DRAIN;
                S_DRAIN: if (in_empty && (outstanding == '0) && !res_valid_q) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase

            if ((in_push && in_full) || (mem_if.mem_resp_valid_in && (outstanding == '0)))
                error_d = 1'b1;

            if (issue) begin
                req_valid_d     = 1'b1;
                req_d.address   = base_q + 64'(head_addr.offset);
                req_d.data      = head_data.field[0];
                req_d.cmd       = cmd_q;
                req_d.id_buffer = id_q;
                id_d            = id_q + MEM_ID_W'(1);
            end else if (mem_if.mem_req_ready_in) begin
                req_valid_d = 1'b0;
            end

            if (resp_hs) begin
                res_valid_d = 1'b1;
                res_d       = meta_dout;
                if (cmd_q == CMD_READ) res_d.field[0] = mem_if.mem_resp_data_in;
            end else if (result_ready_in) begin
                res_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            cmd_q       <= CMD_READ;
            id_q        <= '0;
            req_valid_q <= 1'b0;
            req_q       <= '0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
            prog_full_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            cmd_q       <= cmd_d;
            id_q        <= id_d;
            req_valid_q <= req_valid_d;
            req_q       <= req_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
            prog_full_q <= prog_full_d;
            error_q     <= error_d;
        end
    end

    assign mem_if.mem_req_valid_out  = req_valid_q;
    assign mem_if.mem_req_out        = req_q;
    assign mem_if.mem_resp_ready_out = resp_ready;
    assign result_valid_out          = res_valid_q;
    assign result_out                = res_q;
    assign prog_full_out             = prog_full_q;
    assign done_out                  = (state_q == S_DONE);
    assign error_out                 = error_q;

endmodule

// File: tb/tb_engine_read_write_request_gen.sv
// Scoreboard bench: expected requests/results are queued when packets are
// driven and compared as the request and result handshakes complete.
module tb_engine_read_write_request_gen;
    import global_package::*;

    logic             ap_clk = 1'b0;
    logic             areset_n = 1'b0;
    logic             clear_in = 1'b0;
    logic             start_in = 1'b0;
    logic             done_in = 1'b0;
    logic             cmd_write_in = 1'b0;
    logic [63:0]      base_address_in = '0;
    logic             valid_in = 1'b0;
    PacketDataAddress address_in = '0;
    EnginePacketData  data_in = '0;
    logic             prog_full_out;
    logic             result_valid_out;
    logic             result_ready_in = 1'b1;
    EnginePacketData  result_out;
    logic             done_out;
    logic             error_out;

    engine_read_write_request_gen_if mem_if ();

    engine_read_write_request_gen #(
        .FIFO_DEPTH       (16),
        .PROG_FULL_MARGIN (3),
        .MAX_OUTSTANDING  (8)
    ) dut (
        .ap_clk           (ap_clk),
        .areset_n         (areset_n),
        .clear_in         (clear_in),
        .start_in         (start_in),
        .done_in          (done_in),
        .cmd_write_in     (cmd_write_in),
        .base_address_in  (base_address_in),
        .valid_in         (valid_in),
        .address_in       (address_in),
        .data_in          (data_in),
        .prog_full_out    (prog_full_out),
        .mem_if           (mem_if),
        .result_valid_out (result_valid_out),
        .result_ready_in  (result_ready_in),
        .result_out       (result_out),
        .done_out         (done_out),
        .error_out        (error_out)
    );

    always #5 ap_clk = ~ap_clk;

    MemoryRequestPacket exp_req_q [$];
    logic [31:0]        plan_resp_q [$];
    EnginePacketData    exp_res_q [$];
    logic [31:0]        pend_q [$];

    int          n_tests = 0;
    int          n_fail = 0;
    int          req_cnt = 0;
    int          done_cnt = 0;
    int          budget = 0;
    bit          resp_force = 1'b0;
    bit          track = 1'b1;
    logic [63:0] tb_base = '0;
    ReadWriteCmd tb_cmd = CMD_READ;
    logic [7:0]  tb_id = '0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic flush_model();
        exp_req_q.delete();
        plan_resp_q.delete();
        exp_res_q.delete();
        pend_q.delete();
        tb_id  = '0;
        budget = 0;
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        flush_model();
    endtask

    task automatic do_start(input logic wr, input logic [63:0] base);
        cmd_write_in    = wr;
        base_address_in = base;
        start_in        = 1'b1;
        tb_cmd          = ReadWriteCmd'(wr);
        tb_base         = base;
        tick();
        start_in = 1'b0;
    endtask

    task automatic push_pkt(input logic [31:0] off, input logic [31:0] f0,
                            input logic [31:0] f1, input logic [31:0] rd);
        MemoryRequestPacket r;
        EnginePacketData    d;
        d.field[0] = f0;
        d.field[1] = f1;
        valid_in          = 1'b1;
        address_in.offset = off;
        data_in           = d;
        if (track) begin
            r.address   = tb_base + {32'b0, off};
            r.data      = f0;
            r.cmd       = tb_cmd;
            r.id_buffer = tb_id;
            tb_id++;
            exp_req_q.push_back(r);
            plan_resp_q.push_back(rd);
            if (tb_cmd == CMD_READ) d.field[0] = rd;
            exp_res_q.push_back(d);
        end
        tick();
        valid_in = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_req_valid"}, 128'(mem_if.mem_req_valid_out), 128'(0));
        check_eq({pfx, "_req_pkt"}, 128'(mem_if.mem_req_out), 128'(0));
        check_eq({pfx, "_resp_ready"}, 128'(mem_if.mem_resp_ready_out), 128'(0));
        check_eq({pfx, "_res_valid"}, 128'(result_valid_out), 128'(0));
        check_eq({pfx, "_res_pkt"}, 128'(result_out), 128'(0));
        check_eq({pfx, "_done"}, 128'(done_out), 128'(0));
        check_eq({pfx, "_error"}, 128'(error_out), 128'(0));
        check_eq({pfx, "_prog_full"}, 128'(prog_full_out), 128'(0));
        check_eq({pfx, "_state"}, 128'(dut.state_q), 128'(S_IDLE));
        check_eq({pfx, "_outstanding"}, 128'(dut.outstanding), 128'(0));
    endtask

    // Monitor: handshakes seen here complete at the following rising edge.
    initial forever begin
        @(negedge ap_clk);
        if (done_out) done_cnt++;
        if (mem_if.mem_req_valid_out && mem_if.mem_req_ready_in) begin
            req_cnt++;
            check_eq("req_expected", 128'(exp_req_q.size() != 0), 128'(1));
            if (exp_req_q.size() != 0) begin
                check_eq("req_pkt", 128'(mem_if.mem_req_out), 128'(exp_req_q.pop_front()));
                pend_q.push_back(plan_resp_q.pop_front());
            end
        end
        if (mem_if.mem_resp_valid_in && mem_if.mem_resp_ready_out && pend_q.size() != 0) begin
            void'(pend_q.pop_front());
            if (budget > 0) budget--;
        end
        if (result_valid_out && result_ready_in) begin
            check_eq("res_expected", 128'(exp_res_q.size() != 0), 128'(1));
            if (exp_res_q.size() != 0)
                check_eq("res_pkt", 128'(result_out), 128'(exp_res_q.pop_front()));
        end
    end

    // Memory model: answers accepted requests in order while budget allows.
    initial begin
        mem_if.mem_req_ready_in  = 1'b1;
        mem_if.mem_resp_valid_in = 1'b0;
        mem_if.mem_resp_data_in  = '0;
        forever begin
            @(posedge ap_clk);
            #2;
            if (resp_force) begin
                mem_if.mem_resp_valid_in = 1'b1;
                mem_if.mem_resp_data_in  = '0;
            end else if (pend_q.size() != 0 && budget > 0) begin
                mem_if.mem_resp_valid_in = 1'b1;
                mem_if.mem_resp_data_in  = pend_q[0];
            end else begin
                mem_if.mem_resp_valid_in = 1'b0;
                mem_if.mem_resp_data_in  = '0;
            end
        end
    end

    initial begin
        int snap;

        repeat (3) tick();
        check_reset_outputs("rst0");
        areset_n = 1'b1;
        tick();

        // Read mode, base 0x1000, three offsets.
        do_start(1'b0, 64'h1000);
        check_eq("t1_busy", 128'(dut.state_q), 128'(S_BUSY));
        budget = 1000;
        snap = req_cnt;
        push_pkt(32'd0,  32'h1111, 32'h2222, 32'hA);
        push_pkt(32'd8,  32'h3333, 32'h4444, 32'hB);
        push_pkt(32'd16, 32'h5555, 32'h6666, 32'hC);
        for (int i = 0; i < 100 && exp_res_q.size() != 0; i++) tick();
        check_eq("t1_results_left", 128'(exp_res_q.size()), 128'(0));
        check_eq("t1_req_count", 128'(req_cnt - snap), 128'(3));

        // Outstanding limit with responses withheld.
        budget = 0;
        snap = req_cnt;
        for (int i = 0; i < 12; i++) push_pkt(32'(i * 4), $urandom, $urandom, $urandom);
        repeat (20) tick();
        check_eq("t2_req_count", 128'(req_cnt - snap), 128'(8));
        check_eq("t2_in_count", 128'(dut.in_count), 128'(4));
        check_eq("t2_req_idle", 128'(mem_if.mem_req_valid_out), 128'(0));
        budget = 1;
        for (int i = 0; i < 10 && (req_cnt - snap) < 9; i++) tick();
        repeat (4) tick();
        check_eq("t2_ninth_req", 128'(req_cnt - snap), 128'(9));
        budget = 1000;
        for (int i = 0; i < 200 && exp_res_q.size() != 0; i++) tick();
        check_eq("t2_results_left", 128'(exp_res_q.size()), 128'(0));

        // Downstream stall: responses must back up, nothing lost.
        result_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) push_pkt(32'(64 + i * 8), $urandom, $urandom, $urandom);
        tick();
        for (int i = 0; i < 10; i++) begin
            check_eq("t3_res_valid", 128'(result_valid_out), 128'(1));
            check_eq("t3_res_stable", 128'(result_out), 128'(exp_res_q[0]));
            check_eq("t3_resp_ready", 128'(mem_if.mem_resp_ready_out), 128'(0));
            tick();
        end
        check_eq("t3_no_loss", 128'(exp_res_q.size()), 128'(3));
        result_ready_in = 1'b1;
        for (int i = 0; i < 100 && exp_res_q.size() != 0; i++) tick();
        check_eq("t3_results_left", 128'(exp_res_q.size()), 128'(0));

        // Write mode with address wrap, done_in while two are in flight.
        do_clear();
        do_start(1'b1, 64'hFFFF_FFFF_FFFF_FFF0);
        snap = req_cnt;
        push_pkt(32'h20, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0);
        push_pkt(32'h08, 32'hCAFE_0001, 32'h1234_5678, 32'h0);
        for (int i = 0; i < 20 && (req_cnt - snap) < 2; i++) tick();
        check_eq("t4_outstanding", 128'(dut.outstanding), 128'(2));
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        check_eq("t4_drain", 128'(dut.state_q), 128'(S_DRAIN));
        snap = done_cnt;
        budget = 1000;
        for (int i = 0; i < 60 && dut.state_q != S_IDLE; i++) tick();
        repeat (3) tick();
        check_eq("t4_done_pulses", 128'(done_cnt - snap), 128'(1));
        check_eq("t4_idle", 128'(dut.state_q), 128'(S_IDLE));
        check_eq("t4_results_left", 128'(exp_res_q.size()), 128'(0));

        // Overflow in IDLE: no issue, FIFO fills to 16.
        track = 1'b0;
        mem_if.mem_req_ready_in = 1'b0;
        for (int i = 0; i < 12; i++) push_pkt(32'(i), $urandom, $urandom, 32'h0);
        check_eq("t5_pf_low", 128'(prog_full_out), 128'(0));
        for (int i = 0; i < 2; i++) push_pkt(32'(i), $urandom, $urandom, 32'h0);
        check_eq("t5_pf_high", 128'(prog_full_out), 128'(1));
        for (int i = 0; i < 2; i++) push_pkt(32'(i), $urandom, $urandom, 32'h0);
        check_eq("t5_err_before", 128'(error_out), 128'(0));
        check_eq("t5_count_full", 128'(dut.in_count), 128'(16));
        push_pkt(32'h99, $urandom, $urandom, 32'h0);
        check_eq("t5_err_after", 128'(error_out), 128'(1));
        check_eq("t5_count_held", 128'(dut.in_count), 128'(16));
        do_clear();
        check_eq("t5_clr_err", 128'(error_out), 128'(0));
        check_eq("t5_clr_pf", 128'(prog_full_out), 128'(0));
        check_eq("t5_clr_count", 128'(dut.in_count), 128'(0));
        track = 1'b1;
        mem_if.mem_req_ready_in = 1'b1;

        // Response with nothing outstanding.
        resp_force = 1'b1;
        tick();
        resp_force = 1'b0;
        check_eq("t6_unexp_resp_err", 128'(error_out), 128'(1));
        tick();
        do_clear();
        check_eq("t6_clr_err", 128'(error_out), 128'(0));

        // Asynchronous reset mid-BUSY with three in flight.
        do_start(1'b0, 64'h0);
        snap = req_cnt;
        for (int i = 0; i < 3; i++) push_pkt(32'(i * 8), $urandom, $urandom, $urandom);
        for (int i = 0; i < 20 && (req_cnt - snap) < 3; i++) tick();
        check_eq("t7_outstanding", 128'(dut.outstanding), 128'(3));
        areset_n = 1'b0;
        flush_model();
        tick();
        check_reset_outputs("t7_rst");
        areset_n = 1'b1;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
